// File: rtl/block_transfer_unit.sv
// LDM/STM sequencer: walks a 16-bit register list lowest-first, moving one
// register per memory handshake, then optionally writes back the final base.
module block_transfer_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         load_i,
  input  logic [15:0]  reg_list_i,
  input  logic [N-1:0] base_i,
  input  logic [3:0]   base_reg_i,
  input  logic         increment_i,
  input  logic         before_i,
  input  logic         writeback_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [3:0]   rf_read_addr_o,
  input  logic [N-1:0] rf_read_data_i,
  output logic [3:0]   rf_write_addr1_o,
  output logic [N-1:0] rf_write_data1_o,
  output logic         rf_write_enable1_o,
  output logic [3:0]   rf_write_addr2_o,
  output logic [N-1:0] rf_write_data2_o,
  output logic         rf_write_enable2_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [N-1:0] mem_addr_o,
  output logic [N-1:0] mem_wdata_o,
  input  logic         mem_ready_i,
  input  logic [N-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [N-1:0] WORD = N'(4);

  state_t       state_q, state_d;
  logic         load_q, load_d;
  logic         wb_q, wb_d;
  logic [15:0]  mask_q, mask_d;
  logic [3:0]   base_reg_q, base_reg_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] final_q, final_d;

  logic [4:0]   count;
  logic [3:0]   cur_reg;
  logic [N-1:0] span;
  logic [N-1:0] start_addr;

  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) begin
      count = count + {4'd0, reg_list_i[i]};
    end
  end

  // Lowest set bit of the remaining mask is the register being moved.
  always_comb begin
    cur_reg = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask_q[i]) begin
        cur_reg = 4'(i);
      end
    end
  end

  assign span = N'({count, 2'b00});

  // Decrement modes still walk upward, starting from the lowest address.
  always_comb begin
    start_addr = base_i - span + WORD;
    case ({increment_i, before_i})
      2'b10:   start_addr = base_i;
      2'b11:   start_addr = base_i + WORD;
      2'b01:   start_addr = base_i - span;
      default: start_addr = base_i - span + WORD;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    wb_d       = wb_q;
    mask_d     = mask_q;
    base_reg_d = base_reg_q;
    addr_d     = addr_q;
    final_d    = final_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load_d     = load_i;
          mask_d     = reg_list_i;
          base_reg_d = base_reg_i;
          addr_d     = start_addr;
          final_d    = increment_i ? (base_i + span) : (base_i - span);
          wb_d       = writeback_i & ~(load_i & reg_list_i[base_reg_i]);
          state_d    = (count != 5'd0) ? XFER : FINISH;
        end
      end
      XFER: begin
        if (mem_ready_i) begin
          mask_d = mask_q & (mask_q - 16'd1);
          addr_d = addr_q + WORD;
          if (mask_d == 16'd0) begin
            state_d = FINISH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o             = 1'b0;
    done_o             = 1'b0;
    rf_read_addr_o     = '0;
    rf_write_addr1_o   = '0;
    rf_write_data1_o   = '0;
    rf_write_enable1_o = 1'b0;
    rf_write_addr2_o   = '0;
    rf_write_data2_o   = '0;
    rf_write_enable2_o = 1'b0;
    mem_req_o          = 1'b0;
    mem_we_o           = 1'b0;
    mem_addr_o         = '0;
    mem_wdata_o        = '0;
    case (state_q)
      XFER: begin
        busy_o         = 1'b1;
        mem_req_o      = 1'b1;
        mem_we_o       = ~load_q;
        mem_addr_o     = {addr_q[N-1:2], 2'b00};
        rf_read_addr_o = cur_reg;
        if (load_q) begin
          rf_write_enable1_o = mem_ready_i;
          rf_write_addr1_o   = cur_reg;
          rf_write_data1_o   = mem_rdata_i;
        end else begin
          mem_wdata_o = rf_read_data_i;
        end
      end
      FINISH: begin
        busy_o             = 1'b1;
        done_o             = 1'b1;
        rf_write_enable2_o = wb_q;
        rf_write_addr2_o   = base_reg_q;
        rf_write_data2_o   = final_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      load_q     <= 1'b0;
      wb_q       <= 1'b0;
      mask_q     <= '0;
      base_reg_q <= '0;
      addr_q     <= '0;
      final_q    <= '0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      wb_q       <= wb_d;
      mask_q     <= mask_d;
      base_reg_q <= base_reg_d;
      addr_q     <= addr_d;
      final_q    <= final_d;
    end
  end

endmodule

// File: doc/block_transfer_unit.md
# block_transfer_unit

Multi-register transfer sequencer for the load/store-multiple instruction class (LDM/STM). It walks a 16-bit register list and moves one register per memory handshake. For STM it drives a register-file read address and forwards the read data to memory. For LDM it drives register-file write port 1 with returned memory data. Optional base writeback goes through register-file write port 2. It sits between decode/execute and the data-memory interface, and stalls the core via `busy_o` while sequencing.

## Interface
Parameters:
- `N`, 32, datapath / address width

Ports:
- `clk`  in  1  clock, rising edge
- `rst_ni`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  begin transfer; sampled only in IDLE
- `load_i`  in  1  1 = LDM, 0 = STM
- `reg_list_i`  in  16  bit k set = transfer register k
- `base_i`  in  N  base address value
- `base_reg_i`  in  4  base register number
- `increment_i`  in  1  1 = increment, 0 = decrement
- `before_i`  in  1  1 = adjust before access (IB/DB), 0 = after (IA/DA)
- `writeback_i`  in  1  write final base to `base_reg_i`
- `busy_o`  out  1  high outside IDLE
- `done_o`  out  1  one-cycle pulse in FINISH
- `rf_read_addr_o`  out  4  register-file read address (STM source)
- `rf_read_data_i`  in  N  register-file read data, combinational
- `rf_write_addr1_o`, `rf_write_data1_o`, `rf_write_enable1_o`  out  4/N/1  register-file port 1 (LDM data)
- `rf_write_addr2_o`, `rf_write_data2_o`, `rf_write_enable2_o`  out  4/N/1  register-file port 2 (base writeback)
- `mem_req_o`  out  1  memory request
- `mem_we_o`  out  1  write request (= !load latched)
- `mem_addr_o`  out  N  word address, bits [1:0] always 0
- `mem_wdata_o`  out  N  store data
- `mem_ready_i`  in  1  handshake completes this cycle
- `mem_rdata_i`  in  N  load data, valid when `mem_ready_i`

## Operation
- States: IDLE, XFER, FINISH.
- IDLE, `start_i`=1:
  - latch all command inputs;
  - count C = popcount(`reg_list_i`);
  - go to XFER if C>0, else FINISH.
- Start address by mode:
  - IA: base
  - IB: base+4
  - DA: base−4C+4
  - DB: base−4C
- Transfers always go in ascending register order at ascending addresses, +4 per handshake.
- Final base: base+4C if increment, else base−4C. Arithmetic is modulo 2^N.
- XFER:
  - `mem_req_o`=1; `rf_read_addr_o` = lowest set bit of the remaining mask;
  - `mem_wdata_o` = `rf_read_data_i` (STM);
  - LDM write port 1 is driven combinationally: `rf_write_enable1_o` = load & `mem_ready_i`, address = current register, data = `mem_rdata_i`.
- On `mem_ready_i`: clear the current bit and advance the address. Go to FINISH when the mask becomes empty.
- FINISH:
  - `done_o`=1;
  - `rf_write_enable2_o` = `writeback_i` & !(load & base register in list), address = `base_reg_i`, data = final base;
  - next state IDLE.
- LDM with base in list: the loaded value wins and writeback is suppressed.
- STM with base in list: the stored value is the original base.
- r15 in the list gets no special handling here. The register file's port priority handles PC overwrite.
- `start_i` while busy is ignored.
- Empty list: no memory requests, no register writes, `done_o` one cycle after start.

## Timing
- All outputs are 0 in reset and IDLE, except `rf_read_addr_o`, which is 0.
- Reset asserted mid-transfer: return to IDLE immediately. Outputs drop asynchronously, the in-flight request is abandoned, and no writeback occurs.
- Start accepted at edge k → XFER from cycle k+1.
- Each transfer takes 1 + (cycles `mem_ready_i` low).
- FINISH is one cycle, then IDLE. Minimum total = C+1 cycles after start, or 1 cycle for C=0.
- While `mem_req_o`=1 and `mem_ready_i`=0, `mem_addr_o`, `mem_we_o`, `mem_wdata_o` and `rf_read_addr_o` hold stable.
- LDM register write lands at the same clock edge that completes the handshake.
- `busy_o` is high from cycle k+1 through FINISH inclusive. A new `start_i` is accepted in the cycle after FINISH.

## Test plan
- STM IA, list {r0,r1,r3}, base 0x100, writeback to r13, always ready:
  - expect addresses 0x100/0x104/0x108 with data r0/r1/r3;
  - expect r13 ← 0x10C in FINISH;
  - `done_o` at cycle 4.
- LDM DB, list {r4,r15}, base 0x200, writeback:
  - expect addresses 0x1F8/0x1FC;
  - r4 and r15 written with the memory words;
  - base ← 0x1F8.
- Stall: STM IB {r2}, base 0x40, `mem_ready_i` low for 3 cycles:
  - address 0x44 and data held for 4 cycles;
  - `done_o` at cycle 5.
- LDM IA {r1,r5} with base_reg r5, base 0x80, writeback:
  - r5 ← loaded word from 0x84;
  - `rf_write_enable2_o` stays 0.
- Empty list with `start_i`:
  - `mem_req_o` never asserts;
  - `done_o` at cycle 1;
  - no register writes.
- `rst_ni` low during the second transfer of a 4-register STM:
  - `mem_req_o` and `busy_o` go to 0 immediately;
  - after release the block is in IDLE and accepts a new start.
